// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//
// Decode-to-execute pipeline register of the MIPS pipeline.
//   * Captures the decode control word and operand data into EX, one cycle
//     after they appear in ID.
//   * Detects load-use hazards against the instruction in EX. It raises stall_o
//     for one cycle and inserts a single bubble.
//   * Holds a multi-cycle MUL in EX for MUL_LAT cycles. A small down-counter
//     tracks the remaining hold cycles.
//   * Discards EX contents on a flush resolved in EX (taken branch, j, jr).
//     The flush also aborts a MUL hold.
//
// Parameters
//   BIT_WIDTH  datapath width
//   BIT_SEL    ALUControl is BIT_SEL+1 bits wide
//   MUL_LAT    EX occupancy of a MUL in cycles (>= 1)
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   id_valid                  decode holds a valid instruction
//   id_<ctrl>                 decode control bits, RegDst, ALUControl
//   id_rs/rt/rd/shamt         instruction fields
//   id_rd1/rd2/imm/pc4        operands, sign-extended immediate, PC+4
//   ex_flush                  taken branch / jump / jr resolved in EX
//   ex_<same as id_>          registered copies for the EX stage
//   ex_valid                  EX holds a real instruction
//   ex_wr_reg                 decoded destination register
//   ex_adv                    EX contents move to MEM at the next edge
//   stall_o                   hold PC and IF/ID this cycle
//   stall_cnt                 free-running count of stalled cycles (wraps)
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int BIT_WIDTH = 32,
  parameter int BIT_SEL   = 3,
  parameter int MUL_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 id_valid,
  input  logic                 id_RegWrite,
  input  logic                 id_Branch,
  input  logic                 id_MemWrite,
  input  logic                 id_jump,
  input  logic                 id_jregister,
  input  logic                 id_ALUSrcA,
  input  logic                 id_ALUSrcB,
  input  logic                 id_MemtoReg,
  input  logic [1:0]           id_RegDst,
  input  logic [BIT_SEL:0]     id_ALUControl,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic [4:0]           id_rd,
  input  logic [4:0]           id_shamt,
  input  logic [BIT_WIDTH-1:0] id_rd1,
  input  logic [BIT_WIDTH-1:0] id_rd2,
  input  logic [BIT_WIDTH-1:0] id_imm,
  input  logic [BIT_WIDTH-1:0] id_pc4,

  input  logic                 ex_flush,

  output logic                 ex_RegWrite,
  output logic                 ex_Branch,
  output logic                 ex_MemWrite,
  output logic                 ex_jump,
  output logic                 ex_jregister,
  output logic                 ex_ALUSrcA,
  output logic                 ex_ALUSrcB,
  output logic                 ex_MemtoReg,
  output logic [1:0]           ex_RegDst,
  output logic [BIT_SEL:0]     ex_ALUControl,
  output logic [4:0]           ex_rs,
  output logic [4:0]           ex_rt,
  output logic [4:0]           ex_rd,
  output logic [4:0]           ex_shamt,
  output logic [BIT_WIDTH-1:0] ex_rd1,
  output logic [BIT_WIDTH-1:0] ex_rd2,
  output logic [BIT_WIDTH-1:0] ex_imm,
  output logic [BIT_WIDTH-1:0] ex_pc4,

  output logic                 ex_valid,
  output logic [4:0]           ex_wr_reg,
  output logic                 ex_adv,
  output logic                 stall_o,
  output logic [15:0]          stall_cnt
);

  // The counter must hold MUL_LAT-1. It is never narrower than 3 bits.
  localparam int CNT_W    = ($clog2(MUL_LAT) > 3) ? $clog2(MUL_LAT) : 3;
  localparam int MUL_LOAD = MUL_LAT - 1;
  localparam int ALU_MUL  = 9;

  // Everything that lives in EX, packed so a bubble is simply all-zero.
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 branch;
    logic                 mem_write;
    logic                 jump;
    logic                 jregister;
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic                 mem_to_reg;
    logic [1:0]           reg_dst;
    logic [BIT_SEL:0]     alu_control;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shamt;
    logic [BIT_WIDTH-1:0] rd1;
    logic [BIT_WIDTH-1:0] rd2;
    logic [BIT_WIDTH-1:0] imm;
    logic [BIT_WIDTH-1:0] pc4;
    logic [4:0]           wr_reg;
  } ex_word_t;

  // RUN: no MUL hold pending. MUL_BUSY: cnt_reg != 0.
  // The state is kept in step with the counter.
  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  ex_word_t         ex_reg;
  ex_word_t         ex_next;
  ex_word_t         id_word;
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [15:0]      stall_cnt_reg;

  logic [4:0]       id_wr_reg;
  logic             id_uses_rt;
  logic             id_is_mul;
  logic             load_use;
  logic             mul_hold;

  // ---------------------------------------------------------------------------
  // Decode-side helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    id_wr_reg = 5'd0;
    case (id_RegDst)
      2'd0:    id_wr_reg = id_rt;
      2'd1:    id_wr_reg = id_rd;
      2'd2:    id_wr_reg = 5'd31;
      default: id_wr_reg = 5'd0;
    endcase
  end

  // rt is a source unless the immediate replaces it as ALU operand B.
  // Stores and branches read rt regardless of ALUSrcB.
  assign id_uses_rt = ~id_ALUSrcB | id_MemWrite | id_Branch;
  assign id_is_mul  = (id_ALUControl == ALU_MUL[BIT_SEL:0]);

  always_comb begin
    id_word             = '0;
    id_word.valid       = id_valid;
    id_word.reg_write   = id_RegWrite;
    id_word.branch      = id_Branch;
    id_word.mem_write   = id_MemWrite;
    id_word.jump        = id_jump;
    id_word.jregister   = id_jregister;
    id_word.alu_src_a   = id_ALUSrcA;
    id_word.alu_src_b   = id_ALUSrcB;
    id_word.mem_to_reg  = id_MemtoReg;
    id_word.reg_dst     = id_RegDst;
    id_word.alu_control = id_ALUControl;
    id_word.rs          = id_rs;
    id_word.rt          = id_rt;
    id_word.rd          = id_rd;
    id_word.shamt       = id_shamt;
    id_word.rd1         = id_rd1;
    id_word.rd2         = id_rd2;
    id_word.imm         = id_imm;
    id_word.pc4         = id_pc4;
    id_word.wr_reg      = id_wr_reg;
  end

  // ---------------------------------------------------------------------------
  // Hazard / hold detection
  // ---------------------------------------------------------------------------
  // Load in EX whose result is needed by the instruction in ID. A write to r0
  // carries no data, so it never stalls.
  assign load_use = ex_reg.valid & ex_reg.mem_to_reg & ex_reg.reg_write &
                    (ex_reg.wr_reg != 5'd0) & id_valid &
                    ((ex_reg.wr_reg == id_rs) |
                     (id_uses_rt & (ex_reg.wr_reg == id_rt)));

  assign mul_hold = (state_reg == MUL_BUSY);

  // A flush makes the stall moot: the ID instruction is on the squashed path
  // or gets refetched, and EX is emptied anyway.
  assign stall_o  = ~ex_flush & (mul_hold | load_use);
  assign ex_adv   = ex_reg.valid & ~mul_hold;

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: flush, hold, bubble, capture.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_next  = ex_reg;
    cnt_next = cnt_reg;

    if (ex_flush) begin
      ex_next  = '0;
      cnt_next = '0;
    end else if (mul_hold) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end else if (load_use) begin
      ex_next = '0;
    end else if (id_valid) begin
      ex_next = id_word;
      if (id_is_mul && (MUL_LAT > 1)) begin
        cnt_next = MUL_LOAD[CNT_W-1:0];
      end
    end else begin
      ex_next = '0;
    end

    state_next = (cnt_next != '0) ? MUL_BUSY : RUN;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_reg        <= '0;
      cnt_reg       <= '0;
      state_reg     <= RUN;
      stall_cnt_reg <= 16'd0;
    end else begin
      ex_reg    <= ex_next;
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
      if (stall_o) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ex_valid      = ex_reg.valid;
  assign ex_RegWrite   = ex_reg.reg_write;
  assign ex_Branch     = ex_reg.branch;
  assign ex_MemWrite   = ex_reg.mem_write;
  assign ex_jump       = ex_reg.jump;
  assign ex_jregister  = ex_reg.jregister;
  assign ex_ALUSrcA    = ex_reg.alu_src_a;
  assign ex_ALUSrcB    = ex_reg.alu_src_b;
  assign ex_MemtoReg   = ex_reg.mem_to_reg;
  assign ex_RegDst     = ex_reg.reg_dst;
  assign ex_ALUControl = ex_reg.alu_control;
  assign ex_rs         = ex_reg.rs;
  assign ex_rt         = ex_reg.rt;
  assign ex_rd         = ex_reg.rd;
  assign ex_shamt      = ex_reg.shamt;
  assign ex_rd1        = ex_reg.rd1;
  assign ex_rd2        = ex_reg.rd2;
  assign ex_imm        = ex_reg.imm;
  assign ex_pc4        = ex_reg.pc4;
  assign ex_wr_reg     = ex_reg.wr_reg;
  assign stall_cnt     = stall_cnt_reg;

endmodule
